ula_seq: RTL
============

# ula_seq

Parametrised, registered successor to the single-cycle integer ALU for the MIPS datapath. It covers the full R-type shift, arithmetic, logical and compare set in one registered cycle. It adds an iterative multiply/divide unit with HI/LO registers and `mfhi`/`mflo`. It sits in the EX stage, and the control unit stalls on `busy` until `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a power of two, ≥8.
- `SHW`, `$clog2(WIDTH)`, shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted on a rising edge when `start && !busy`.
- `OP`  in  5  operation code (see Operation).
- `In1`  in  WIDTH  operand A (rs).
- `In2`  in  WIDTH  operand B (rt).
- `shamt`  in  SHW  immediate shift amount.
- `result`  out  WIDTH  registered result.
- `Zero_flag`  out  1  `result == 0`, derived from the registered `result`.
- `HI`  out  WIDTH  high product / remainder register.
- `LO`  out  WIDTH  low product / quotient register.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle pulse when `result` or HI/LO become valid.
- `div_by_zero`  out  1  sticky until next accepted start; set by div/divu with `In2 == 0`.

## Operation
- Single-cycle ops:
  - `00000` sll: `In1 << shamt`
  - `00001` srl: logical right by `shamt`
  - `00010` sra: arithmetic right by `shamt`
  - `00011` sllv, `00100` srlv, `00101` srav: as above, but the amount is `In2[SHW-1:0]`
  - `00110` add, `00111` sub: wrap modulo 2^WIDTH, no overflow trap
  - `01000` and, `01001` or, `01010` xor
  - `01011` nor: bitwise `~(In1|In2)`
  - `01100` slt: signed compare, result zero-extended to WIDTH
  - `01101` sltu: unsigned compare, result zero-extended to WIDTH
- HI/LO access ops, also single-cycle:
  - `10100` mfhi: `result = HI`
  - `10101` mflo: `result = LO`
- Multi-cycle ops; these write HI/LO and leave `result` unchanged:
  - `10000` mult, signed: `{HI,LO}` = full 2·WIDTH product.
  - `10001` multu, unsigned: `{HI,LO}` = full 2·WIDTH product.
  - `10010` div, signed: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `10011` divu, unsigned: LO = quotient, HI = remainder.
- Any other OP: `result = 0`, `done` pulses, HI/LO unchanged.
- State machine:
  - `IDLE`: on accepted mult/div start → `MUL` or `DIV`; operands are latched and converted to magnitudes for signed ops.
  - `MUL` / `DIV`: one shift-add or restoring-subtract step per cycle, WIDTH steps → `FIN`.
  - `FIN`: sign fix-up, HI/LO write, `done` → `IDLE`.
- Division by zero: no iteration; HI = `In1`, LO = all ones, `div_by_zero` = 1, goes directly to `FIN`.
- Signed overflow (MIN / −1): LO = MIN, HI = 0, no flag.

## Timing
- Reset values:
  - `result`, `HI`, `LO` = 0
  - `busy`, `done`, `div_by_zero` = 0
  - state = `IDLE`
  - `Zero_flag` = 1
- Single-cycle op accepted at edge k: `result` is valid and `done` = 1 in the cycle after k; `busy` stays 0.
- Back-to-back single-cycle ops are allowed every cycle.
- Mult/div accepted at edge k:
  - `busy` = 1 from cycle k+1.
  - HI/LO valid and `done` = 1 in cycle k+WIDTH+1.
  - `busy` = 0 in that same cycle.
- Divide-by-zero: `done` in cycle k+2.
- `start` while `busy` is ignored; no queuing.
- A start accepted in the `done` cycle is legal.
- mfhi/mflo accepted in the `done` cycle return the new HI/LO.
- `reset` mid-operation aborts the op: all outputs take their reset values on the next edge, with no `done`.
- Operands are sampled only at acceptance; later changes to `In1`/`In2` have no effect.

## Configuration
- `ULA_SEQ_DIV_EN`: divider compiled in.
- Without it:
  - `10010`/`10011` behave as illegal OP: single-cycle, `result = 0`, `done` pulses, HI/LO unchanged.
  - `div_by_zero` is tied to 0.
  - The `DIV` state and the subtractor are removed.
- Multiply is always present.

## Structure
- Shared package `ula_pkg` holds:
  - the OP encoding enum `ula_op_e`
  - the state enum `ula_state_e`
  - a helper function `is_multicycle(op)`
- Natural sub-module: `ula_md_iter`, the iterative multiply/divide datapath. It holds a WIDTH-step counter and operand/accumulator registers, and has a `go`/`fin` handshake with the parent FSM.
- The parent `ula_seq` owns the single-cycle ALU, the FSM, HI/LO and sign fix-up.

## Test plan
- add `5+7`, then sub `3-5`: `result` = 12, then 0xFFFFFFFE, each with `done` one cycle after accept; sub `7-7` → `Zero_flag` = 1.
- sra 0x80000000 by `shamt` = 4 → 0xF8000000; srl → 0x08000000; slt(−1, 1) = 1; sltu(−1, 1) = 0.
- mult −3 × 5: `busy` for 32 cycles, `done` at k+33, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; then mflo → `result` = 0xFFFFFFF1.
- div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu 7 / 0 → HI = 7, LO = 0xFFFFFFFF, `div_by_zero` = 1, `done` at k+2.
- `start` pulsed every cycle during a multu: extra starts ignored, exactly one `done`, result unaffected.
- `reset` asserted at cycle k+10 of a mult → HI = LO = 0, `busy` = 0 next cycle, no `done`; then add accepted normally.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared OP/state encodings for ula_seq; honours ULA_SEQ_DIV_EN
package ula_pkg;

   typedef enum logic [4:0] {
      OP_SLL   = 5'b00000,
      OP_SRL   = 5'b00001,
      OP_SRA   = 5'b00010,
      OP_SLLV  = 5'b00011,
      OP_SRLV  = 5'b00100,
      OP_SRAV  = 5'b00101,
      OP_ADD   = 5'b00110,
      OP_SUB   = 5'b00111,
      OP_AND   = 5'b01000,
      OP_OR    = 5'b01001,
      OP_XOR   = 5'b01010,
      OP_NOR   = 5'b01011,
      OP_SLT   = 5'b01100,
      OP_SLTU  = 5'b01101,
      OP_MULT  = 5'b10000,
      OP_MULTU = 5'b10001,
      OP_DIV   = 5'b10010,
      OP_DIVU  = 5'b10011,
      OP_MFHI  = 5'b10100,
      OP_MFLO  = 5'b10101
   } ula_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
`ifdef ULA_SEQ_DIV_EN
      DIV  = 2'd2,
`endif
      FIN  = 2'd3
   } ula_state_e;

   // Without the divider, div/divu fall through as illegal single-cycle ops.
   function automatic logic is_multicycle(input ula_op_e op);
      case (op)
         OP_MULT, OP_MULTU: return 1'b1;
`ifdef ULA_SEQ_DIV_EN
         OP_DIV, OP_DIVU:   return 1'b1;
`endif
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ula_md_iter.sv
// rtl/ula_md_iter.sv - iterative shift-add multiplier / restoring divider on magnitudes
// Divider datapath present only with ULA_SEQ_DIV_EN.
module ula_md_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             en,
`ifdef ULA_SEQ_DIV_EN
   input  logic             div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fin,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic [WIDTH-1:0] src_hi, src_lo, src_op;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;
   logic [WIDTH:0]   sum;
`ifdef ULA_SEQ_DIV_EN
   logic             div_q, mode_div;
   logic [WIDTH:0]   shifted, diff;

   assign mode_div = go ? div : div_q;
`endif

   // The first step is taken on the load edge so WIDTH steps fit in WIDTH-1 busy cycles plus FIN.
   always_comb begin
      src_hi = go ? '0 : acc_hi;
      src_lo = go ? a  : acc_lo;
      src_op = go ? b  : opnd;
      sum    = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_op} : '0);
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
`ifdef ULA_SEQ_DIV_EN
      shifted = {src_hi, src_lo[WIDTH-1]};
      diff    = shifted - {1'b0, src_op};
      if (mode_div) begin
         nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         nxt_lo = {src_lo[WIDTH-2:0], ~diff[WIDTH]};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
`ifdef ULA_SEQ_DIV_EN
         div_q  <= 1'b0;
`endif
      end else if (go || en) begin
         acc_hi <= nxt_hi;
         acc_lo <= nxt_lo;
         opnd   <= src_op;
         cnt    <= go ? CW'(1) : cnt + 1'b1;
`ifdef ULA_SEQ_DIV_EN
         if (go)
            div_q <= div;
`endif
      end
   end

   assign fin = (cnt == CW'(WIDTH - 1));
   assign hi  = acc_hi;
   assign lo  = acc_lo;

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - registered MIPS ALU with iterative mult/div and HI/LO
// Divider and div_by_zero are compiled in only with ULA_SEQ_DIV_EN.
module ula_seq
   import ula_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       OP,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] result,
   output logic             Zero_flag,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   ula_op_e            op;
   ula_state_e         state;
   logic [WIDTH-1:0]   alu;
   logic               sgn, go, fin, flip;
   logic [WIDTH-1:0]   a_mag, b_mag, it_hi, it_lo;
   logic [2*WIDTH-1:0] prod;

   assign op        = ula_op_e'(OP);
   assign Zero_flag = (result == '0);
   assign sgn       = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag     = (sgn && In1[WIDTH-1]) ? -In1 : In1;
   assign b_mag     = (sgn && In2[WIDTH-1]) ? -In2 : In2;
   assign prod      = flip ? -{it_hi, it_lo} : {it_hi, it_lo};

`ifdef ULA_SEQ_DIV_EN
   logic             is_div, div_q, flip_rem, dbz_q;
   logic [WIDTH-1:0] dz_a, quo, rem;

   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign quo    = flip ? -it_lo : it_lo;
   assign rem    = flip_rem ? -it_hi : it_hi;
   assign go     = start && (state == IDLE) && is_multicycle(op) && !(is_div && In2 == '0);
`else
   assign go          = start && (state == IDLE) && is_multicycle(op);
   assign div_by_zero = 1'b0;
`endif

   always_comb begin
      alu = '0;
      case (op)
         OP_SLL:  alu = In1 << shamt;
         OP_SRL:  alu = In1 >> shamt;
         OP_SRA:  alu = $signed(In1) >>> shamt;
         OP_SLLV: alu = In1 << In2[SHW-1:0];
         OP_SRLV: alu = In1 >> In2[SHW-1:0];
         OP_SRAV: alu = $signed(In1) >>> In2[SHW-1:0];
         OP_ADD:  alu = In1 + In2;
         OP_SUB:  alu = In1 - In2;
         OP_AND:  alu = In1 & In2;
         OP_OR:   alu = In1 | In2;
         OP_XOR:  alu = In1 ^ In2;
         OP_NOR:  alu = ~(In1 | In2);
         OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(In1) < $signed(In2)};
         OP_SLTU: alu = {{(WIDTH-1){1'b0}}, In1 < In2};
         OP_MFHI: alu = HI;
         OP_MFLO: alu = LO;
         default: alu = '0;
      endcase
   end

   ula_md_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .reset (reset),
      .go    (go),
      .en    (state != IDLE && state != FIN),
`ifdef ULA_SEQ_DIV_EN
      .div   (is_div),
`endif
      .a     (a_mag),
      .b     (b_mag),
      .fin   (fin),
      .hi    (it_hi),
      .lo    (it_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         result   <= '0;
         HI       <= '0;
         LO       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         flip     <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
         div_by_zero <= 1'b0;
         div_q    <= 1'b0;
         flip_rem <= 1'b0;
         dbz_q    <= 1'b0;
         dz_a     <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
`ifdef ULA_SEQ_DIV_EN
                  div_by_zero <= 1'b0;
`endif
                  if (is_multicycle(op)) begin
                     busy <= 1'b1;
                     flip <= sgn && (In1[WIDTH-1] ^ In2[WIDTH-1]);
`ifdef ULA_SEQ_DIV_EN
                     div_q    <= is_div;
                     flip_rem <= sgn && In1[WIDTH-1];
                     dbz_q    <= 1'b0;
                     if (!is_div)
                        state <= MUL;
                     else if (In2 == '0) begin
                        dbz_q       <= 1'b1;
                        div_by_zero <= 1'b1;
                        dz_a        <= In1;
                        state       <= FIN;
                     end else
                        state <= DIV;
`else
                     state <= MUL;
`endif
                  end else begin
                     result <= alu;
                     done   <= 1'b1;
                  end
               end
            end
            MUL: if (fin) state <= FIN;
`ifdef ULA_SEQ_DIV_EN
            DIV: if (fin) state <= FIN;
`endif
            FIN: begin
`ifdef ULA_SEQ_DIV_EN
               if (dbz_q) begin
                  HI <= dz_a;
                  LO <= '1;
               end else if (div_q) begin
                  HI <= rem;
                  LO <= quo;
               end else
                  {HI, LO} <= prod;
`else
               {HI, LO} <= prod;
`endif
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
